register_file: RTL and testbench

- 16 x 32-bit general register bank for the basic RISC data path.
- Sits directly downstream of the register-address multiplexers.
  - Port A read address comes from the A-address mux, which can force address 15 (the PC/link register).
  - Port B read address and the write address come from their own muxes.
- Provides two combinational read ports, one synchronous write port, and a dedicated PC increment path on R15.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/register_cell.sv | 28 ++
 rtl/register_file.sv | 75 +++++++
 tb/tb_register_file.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register bank and the register-address muxes.
// The control unit, the A-address mux and the register file use these so all three agree that R15 is the PC.
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int REG_PC = 15;
  localparam int PC_INC = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ASEL_RS1 = 2'd0,
    ASEL_RD  = 2'd1,
    ASEL_PC  = 2'd2
  } amux_sel_e;

  function automatic addr_t amux_addr(input amux_sel_e sel, input addr_t rs1, input addr_t rd);
    case (sel)
      ASEL_RD: return rd;
      ASEL_PC: return addr_t'(REG_PC);
      default: return rs1;
    endcase
  endfunction
endpackage

// File: rtl/register_cell.sv
// One storage word of the register bank: sync active-low clear, load enable, optional increment.
// A load takes priority over an increment presented on the same edge.
module register_cell #(
  parameter int DATA_W  = 32,
  parameter bit HAS_INC = 1'b0,
  parameter int INC_VAL = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load_en,
  input  logic [DATA_W-1:0] i_load_dat,
  input  logic              i_inc_en,
  output logic [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_load_en) begin
      r_q <= i_load_dat;
    end else if (HAS_INC && i_inc_en) begin
      r_q <= r_q + DATA_W'(INC_VAL);
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/register_file.sv
// 16 x 32 register bank: two combinational read ports, one synchronous write port, R15 doubles as the PC.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports and pc_out.
module register_file #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = 16,
  parameter int PC_INC   = regfile_pkg::PC_INC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] rw_addr,
  input  logic [DATA_W-1:0] rw_data,
  input  logic              rw_en,
  input  logic              pc_inc_en,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] pc_out
);
  import regfile_pkg::*;

  logic [DATA_W-1:0]   w_q [NUM_REGS];
  logic [NUM_REGS-1:0] w_we;
  logic [DATA_W-1:0]   w_ra_reg;
  logic [DATA_W-1:0]   w_rb_reg;
  logic [DATA_W-1:0]   w_pc_reg;

  // Out-of-range write addresses decode to no enable, so they are dropped here.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign w_we[gi] = rw_en && (rw_addr == ADDR_W'(gi));

    register_cell #(
      .DATA_W  (DATA_W),
      .HAS_INC (gi == REG_PC),
      .INC_VAL (PC_INC)
    ) u_cell (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load_en  (w_we[gi]),
      .i_load_dat (rw_data),
      .i_inc_en   (pc_inc_en),
      .o_q        (w_q[gi])
    );
  end

  if (NUM_REGS > REG_PC) begin : g_pc
    assign w_pc_reg = w_q[REG_PC];
  end else begin : g_no_pc
    assign w_pc_reg = '0;
  end

  // Unmatched addresses fall through to zero.
  always_comb begin
    w_ra_reg = '0;
    w_rb_reg = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ra_addr == ADDR_W'(i)) w_ra_reg = w_q[i];
      if (rb_addr == ADDR_W'(i)) w_rb_reg = w_q[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_wr_vld;

  assign w_wr_vld = |w_we;
  assign ra_data  = (w_wr_vld && (rw_addr == ra_addr)) ? rw_data : w_ra_reg;
  assign rb_data  = (w_wr_vld && (rw_addr == rb_addr)) ? rw_data : w_rb_reg;
  assign pc_out   = (w_wr_vld && (rw_addr == ADDR_W'(REG_PC))) ? rw_data : w_pc_reg;
`else
  assign ra_data  = w_ra_reg;
  assign rb_data  = w_rb_reg;
  assign pc_out   = w_pc_reg;
`endif
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a 16-entry instance plus an 8-entry instance sharing the same inputs.
module tb_register_file;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [3:0]  ra_addr, rb_addr, rw_addr;
  logic [31:0] rw_data;
  logic        rw_en, pc_inc_en;
  logic [31:0] ra_data, rb_data, pc_out;
  logic [31:0] ra8, rb8, pc8;

  register_file u_dut (
    .clk(clk), .reset_n(reset_n), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .rw_addr(rw_addr), .rw_data(rw_data), .rw_en(rw_en), .pc_inc_en(pc_inc_en),
    .ra_data(ra_data), .rb_data(rb_data), .pc_out(pc_out)
  );

  register_file #(.NUM_REGS(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .rw_addr(rw_addr), .rw_data(rw_data), .rw_en(rw_en), .pc_inc_en(pc_inc_en),
    .ra_data(ra8), .rb_data(rb8), .pc_out(pc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_e;
  logic [31:0] m_act;
  int          n_checks = 0;
  int          n_errors = 0;

  // Monitor: every falling edge, drain whatever the stimulus queued for the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      case (m_e.kind)
        0:       m_act = ra_data;
        1:       m_act = rb_data;
        2:       m_act = pc_out;
        3:       m_act = ra8;
        4:       m_act = rb8;
        default: m_act = pc8;
      endcase
      n_checks++;
      if (m_act !== m_e.val) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", m_e.tag, m_act, m_e.val);
      end
    end
  end

  task automatic drive(input logic rst, input logic [3:0] ra, input logic [3:0] rb,
                       input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic inc);
    reset_n   = rst;
    ra_addr   = ra;
    rb_addr   = rb;
    rw_en     = we;
    rw_addr   = wa;
    rw_data   = wd;
    pc_inc_en = inc;
  endtask

  task automatic expect_v(input int kind, input logic [31:0] val, input string tag);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] byp(input logic [31:0] old_v, input logic [31:0] new_v);
    return BYP ? new_v : old_v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
    tick();

    // Reset state.
    drive(1'b1, 4'd3, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(0, 32'h0, "reset_ra");
    expect_v(1, 32'h0, "reset_rb");
    expect_v(2, 32'h0, "reset_pc");
    tick();

    // Write R3, then a reset cycle that also carries a write and an increment.
    drive(1'b1, 4'd3, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
    expect_v(0, byp(32'h0, 32'hDEADBEEF), "r3_during_write");
    tick();
    drive(1'b1, 4'd3, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(0, 32'hDEADBEEF, "r3_after_write");
    tick();
    drive(1'b0, 4'd3, 4'd0, 1'b1, 4'd3, 32'h12345678, 1'b1);
    tick();
    drive(1'b1, 4'd3, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(0, 32'h0, "r3_after_reset");
    expect_v(2, 32'h0, "pc_after_reset");
    tick();

    // Two-port write/read.
    drive(1'b1, 4'd1, 4'd1, 1'b1, 4'd1, 32'h11111111, 1'b0);
    expect_v(0, byp(32'h0, 32'h11111111), "r1_ra_during_write");
    expect_v(1, byp(32'h0, 32'h11111111), "r1_rb_during_write");
    tick();
    drive(1'b1, 4'd1, 4'd2, 1'b1, 4'd2, 32'h22222222, 1'b0);
    expect_v(0, 32'h11111111, "r1_ra_after_write");
    expect_v(1, byp(32'h0, 32'h22222222), "r2_rb_during_write");
    tick();
    drive(1'b1, 4'd1, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(0, 32'h11111111, "r1_ra");
    expect_v(1, 32'h22222222, "r2_rb");
    tick();
    drive(1'b1, 4'd2, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(0, 32'h22222222, "r2_ra_same");
    expect_v(1, 32'h22222222, "r2_rb_same");
    tick();

    // PC increments from zero: 0, 4, 8 seen during the inc cycles, then 12.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1);
      expect_v(2, 32'(4 * k), "pc_inc_seq");
      tick();
    end
    drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(2, 32'd12, "pc_after_3_inc");
    tick();

    // Wrap-around.
    drive(1'b1, 4'd0, 4'd0, 1'b1, 4'd15, 32'hFFFFFFFC, 1'b0);
    expect_v(2, byp(32'd12, 32'hFFFFFFFC), "pc_during_preload");
    tick();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1);
    expect_v(2, 32'hFFFFFFFC, "pc_preloaded");
    tick();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(2, 32'h0, "pc_wrap");
    tick();

    // Write to R15 beats the increment; write to R5 and increment coexist.
    drive(1'b1, 4'd0, 4'd0, 1'b1, 4'd15, 32'h100, 1'b1);
    tick();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(2, 32'h100, "pc_write_priority");
    tick();
    drive(1'b1, 4'd5, 4'd0, 1'b1, 4'd5, 32'h55AA55AA, 1'b1);
    expect_v(0, byp(32'h0, 32'h55AA55AA), "r5_during_write");
    expect_v(2, 32'h100, "pc_no_inc_bypass");
    tick();
    drive(1'b1, 4'd5, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(0, 32'h55AA55AA, "r5_with_inc");
    expect_v(2, 32'h104, "pc_inc_with_r5");
    tick();

    // Forced-15 read through the A-address mux encoding.
    drive(1'b1, 4'd0, 4'd0, 1'b1, 4'd15, 32'h40, 1'b0);
    tick();
    drive(1'b1, amux_addr(ASEL_PC, 4'd3, 4'd9), 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(0, 32'h40, "forced15_ra");
    expect_v(2, 32'h40, "forced15_pc");
    tick();

    // Same-cycle read of a register being written.
    drive(1'b1, 4'd7, 4'd7, 1'b1, 4'd7, 32'hCAFE0001, 1'b0);
    expect_v(0, byp(32'h0, 32'hCAFE0001), "r7_ra_during_write");
    expect_v(1, byp(32'h0, 32'hCAFE0001), "r7_rb_during_write");
    tick();
    drive(1'b1, 4'd7, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(0, 32'hCAFE0001, "r7_after_write");
    tick();

    // Out-of-range addresses on the 8-entry instance.
    drive(1'b1, 4'd9, 4'd1, 1'b1, 4'd9, 32'h99999999, 1'b0);
    expect_v(3, 32'h0, "n8_ra9_during_write");
    expect_v(4, 32'h11111111, "n8_rb1_during_write");
    tick();
    drive(1'b1, 4'd9, 4'd1, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(3, 32'h0, "n8_ra9_after_write");
    expect_v(4, 32'h11111111, "n8_rb1_unchanged");
    expect_v(0, 32'h99999999, "n16_r9");
    tick();
    drive(1'b1, 4'd15, 4'd7, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_v(3, 32'h0, "n8_ra15");
    expect_v(4, 32'hCAFE0001, "n8_rb7");
    expect_v(5, 32'h0, "n8_pc");
    tick();

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
